// File: rtl/msu_sched.sv
// Round-robin scheduler that time-shares one modular squarer among NUM_REQ requesters.
// Optional iteration watchdog: define MSU_SCHED_WDOG_EN.

package redun_mont_pkg;
  localparam int DAT_BITS = 16;
  localparam int TOT_BITS = 20;
endpackage

module msu_sched #(
  parameter int NUM_REQ     = 4,
  parameter int SQ_IN_BITS  = redun_mont_pkg::DAT_BITS,
  parameter int SQ_OUT_BITS = redun_mont_pkg::TOT_BITS,
  parameter int T_LEN       = 64,
  parameter int WDOG_BITS   = 10,
  localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*T_LEN-1:0]      req_t_final,
  input  logic [NUM_REQ*SQ_IN_BITS-1:0] req_sq_in,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [T_LEN-1:0]              rsp_t,
  output logic [SQ_OUT_BITS-1:0]        rsp_sq,
  output logic                          sq_reset,
  output logic                          sq_start,
  output logic [SQ_IN_BITS-1:0]         sq_in,
  input  logic                          sq_valid,
  input  logic [SQ_OUT_BITS-1:0]        sq_out,
  input  logic                          sq_locked,
  output logic                          busy
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GRANT   = 3'd1,
    S_START   = 3'd2,
    S_COMPUTE = 3'd3,
    S_RESULT  = 3'd4,
    S_FLUSH   = 3'd5
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ID_W-1:0]         r_ptr;
  logic [ID_W-1:0]         r_id;
  logic [T_LEN-1:0]        r_cnt;
  logic [T_LEN-1:0]        r_t_final;
  logic [T_LEN-1:0]        r_rsp_t;
  logic [SQ_OUT_BITS-1:0]  r_rsp_sq;
  logic [SQ_IN_BITS-1:0]   r_sq_in;
  logic [NUM_REQ-1:0]      r_req_ready;
  logic                    r_rsp_valid;
  logic                    r_sq_start;
  logic                    r_sq_reset;
  logic                    r_busy;
  logic [T_LEN-1:0]        w_cnt_inc;
  logic [ID_W-1:0]         w_win_id;
  logic [ID_W-1:0]         w_idx;
  logic [ID_W-1:0]         w_ptr_nxt;
  logic                    w_win_found;
  logic                    w_done;
  logic                    w_wdog_to;
  logic [T_LEN-1:0]        w_tf [NUM_REQ];
  logic [SQ_IN_BITS-1:0]   w_si [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign w_tf[g] = req_t_final[g*T_LEN +: T_LEN];
    assign w_si[g] = req_sq_in[g*SQ_IN_BITS +: SQ_IN_BITS];
  end

  assign w_cnt_inc = r_cnt + T_LEN'(1);
  assign w_done    = sq_valid && (w_cnt_inc == r_t_final);
  assign w_ptr_nxt = (w_win_id == ID_W'(NUM_REQ - 1)) ? '0 : w_win_id + ID_W'(1);

`ifdef MSU_SCHED_WDOG_EN
  logic [WDOG_BITS-1:0] r_wdog;

  // Watchdog: counts COMPUTE cycles since the last squarer pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wdog <= '0;
    end else if ((r_state != S_COMPUTE) || sq_valid) begin
      r_wdog <= '0;
    end else begin
      r_wdog <= r_wdog + WDOG_BITS'(1);
    end
  end

  assign w_wdog_to = (r_state == S_COMPUTE) && (&r_wdog) && !sq_valid;
`else
  // No watchdog in this build; the width parameter stays for a uniform interface.
  assign w_wdog_to = (WDOG_BITS < 0);
`endif

  // Round-robin search starting at the grant pointer.
  always_comb begin
    w_win_found = 1'b0;
    w_win_id    = '0;
    w_idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = ID_W'((int'(r_ptr) + k) % NUM_REQ);
      if (!w_win_found && req_valid[w_idx]) begin
        w_win_found = 1'b1;
        w_win_id    = w_idx;
      end else begin
        w_win_found = w_win_found;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_found && sq_locked) w_state_nxt = S_GRANT;
        else                          w_state_nxt = S_IDLE;
      end
      S_GRANT: begin
        if (w_tf[r_id] == '0) w_state_nxt = S_RESULT;
        else                  w_state_nxt = S_START;
      end
      S_START: begin
        if (!sq_locked) w_state_nxt = S_RESULT;
        else            w_state_nxt = S_COMPUTE;
      end
      S_COMPUTE: begin
        if (!sq_locked || w_done || w_wdog_to) w_state_nxt = S_RESULT;
        else                                   w_state_nxt = S_COMPUTE;
      end
      S_RESULT: begin
        if (rsp_ready) w_state_nxt = S_FLUSH;
        else           w_state_nxt = S_RESULT;
      end
      S_FLUSH: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Control outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr       <= '0;
      r_cnt       <= '0;
      r_req_ready <= '0;
      r_rsp_valid <= 1'b0;
      r_sq_start  <= 1'b0;
      r_sq_reset  <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) && (w_state_nxt == S_GRANT)) begin
        r_ptr       <= w_ptr_nxt;
        r_req_ready <= NUM_REQ'(1) << w_win_id;
      end else begin
        r_req_ready <= '0;
      end
      if (r_state != S_COMPUTE)          r_cnt <= '0;
      else if (sq_valid && sq_locked)    r_cnt <= w_cnt_inc;
      r_rsp_valid <= (w_state_nxt == S_RESULT);
      r_sq_start  <= (w_state_nxt == S_START);
      r_sq_reset  <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_FLUSH);
      r_busy      <= (w_state_nxt != S_IDLE);
    end
  end

  // Job and result data; deliberately left without reset.
  always_ff @(posedge clk) begin
    case (r_state)
      S_IDLE: begin
        if (w_state_nxt == S_GRANT) r_id <= w_win_id;
      end
      S_GRANT: begin
        r_t_final <= w_tf[r_id];
        r_sq_in   <= w_si[r_id];
        if (w_tf[r_id] == '0) begin
          r_rsp_sq <= SQ_OUT_BITS'(w_si[r_id]);
          r_rsp_t  <= '0;
        end
      end
      S_START: begin
        if (!sq_locked) r_rsp_t <= '1;
      end
      S_COMPUTE: begin
        if (!sq_locked) begin
          r_rsp_t <= '1;
        end else if (sq_valid) begin
          r_rsp_sq <= sq_out;
          if (w_done) r_rsp_t <= r_t_final;
        end else if (w_wdog_to) begin
          r_rsp_t <= '1;
        end
      end
      default: begin
      end
    endcase
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_t     = r_rsp_t;
  assign rsp_sq    = r_rsp_sq;
  assign sq_reset  = r_sq_reset;
  assign sq_start  = r_sq_start;
  assign sq_in     = r_sq_in;
  assign busy      = r_busy;

endmodule

// File: tb/tb_msu_sched.sv
// Self-checking bench for msu_sched: vector table, hand-written corner sequences and
// randomized jobs against a behavioural squarer and round-robin reference model.

module tb_msu_sched;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_t_final;
  logic [63:0]  req_sq_in;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [1:0]   rsp_id;
  logic [63:0]  rsp_t;
  logic [19:0]  rsp_sq;
  logic         sq_reset;
  logic         sq_start;
  logic [15:0]  sq_in;
  logic         sq_valid;
  logic [19:0]  sq_out;
  logic         sq_locked;
  logic         busy;

  logic [63:0]  tb_tf [4];
  logic [15:0]  tb_si [4];

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;

  int  sq_period = 1;
  int  max_pulses = 1000000;
  int  n_pulses = 0;
  int  n_starts = 0;
  int  wait_cnt = 0;
  bit  run = 1'b0;
  logic [19:0] x_cur;
  time last_pulse_t = 0;

  typedef struct {
    logic [3:0]  vm;
    logic [63:0] tf;
    logic [15:0] si;
    int          period;
    int          exp_id;
    logic [63:0] exp_t;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_pack
    assign req_t_final[g*64 +: 64] = tb_tf[g];
    assign req_sq_in[g*16 +: 16]   = tb_si[g];
  end

  msu_sched #(
    .NUM_REQ(4), .SQ_IN_BITS(16), .SQ_OUT_BITS(20), .T_LEN(64), .WDOG_BITS(10)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_t_final(req_t_final), .req_sq_in(req_sq_in),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_t(rsp_t), .rsp_sq(rsp_sq),
    .sq_reset(sq_reset), .sq_start(sq_start), .sq_in(sq_in),
    .sq_valid(sq_valid), .sq_out(sq_out), .sq_locked(sq_locked),
    .busy(busy)
  );

  function automatic logic [19:0] sq_f(input logic [19:0] v);
    logic [39:0] p;
    p = {20'b0, v} * {20'b0, v};
    return p[19:0] + 20'd3;
  endfunction

  function automatic logic [19:0] ref_sq(input logic [15:0] v, input logic [63:0] t);
    logic [19:0] x;
    x = {4'b0, v};
    for (longint i = 0; i < longint'(t); i++) x = sq_f(x);
    return x;
  endfunction

  function automatic int model_win(input logic [3:0] vm);
    for (int k = 0; k < 4; k++) begin
      if (vm[(model_ptr + k) % 4]) return (model_ptr + k) % 4;
    end
    return 0;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural squarer: one iteration every sq_period cycles after a start pulse.
  initial begin
    sq_valid = 1'b0;
    sq_out   = 20'd0;
    x_cur    = 20'd0;
    forever begin
      @(posedge clk);
      #1;
      sq_valid = 1'b0;
      if (sq_start) begin
        run = 1'b1; x_cur = {4'b0, sq_in}; wait_cnt = 0; n_pulses = 0; n_starts++;
      end else if (sq_reset) begin
        run = 1'b0;
      end else if (run && (n_pulses < max_pulses)) begin
        wait_cnt++;
        if (wait_cnt >= sq_period) begin
          wait_cnt = 0; x_cur = sq_f(x_cur); sq_out = x_cur; sq_valid = 1'b1;
          n_pulses++; last_pulse_t = $time;
        end
      end
    end
  end

  task automatic do_job(input logic [3:0] vm, input int exp_id, input logic [63:0] et,
                        input bit hold, input int rdy_delay, input string nm);
    int n;
    int st0;
    bit stable;
    logic [3:0]  one_hot;
    logic [19:0] es;
    st0 = n_starts;
    req_valid = vm;
    n = 0;
    while ((req_ready == 4'b0) && (n < 40)) begin step(); n++; end
    one_hot = 4'b0001 << exp_id;
    chk({nm, ".grant"}, 64'(req_ready), 64'(one_hot));
    model_ptr = (exp_id + 1) % 4;
    es = ref_sq(tb_si[exp_id], tb_tf[exp_id]);
    if (!hold) req_valid = 4'b0;
    n = 0;
    while (!rsp_valid && (n < 2000)) begin step(); n++; end
    chk({nm, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
    if (et == 64'd0) chk({nm, ".zero_latency"}, 64'(n), 64'd1);
    chk({nm, ".rsp_id"}, 64'(rsp_id), 64'(exp_id));
    chk({nm, ".rsp_t"}, rsp_t, et);
    chk({nm, ".rsp_sq"}, 64'(rsp_sq), 64'(es));
    chk({nm, ".starts"}, 64'(n_starts - st0), (et == 64'd0) ? 64'd0 : 64'd1);
    if (rdy_delay > 0) begin
      stable = 1'b1;
      req_valid = 4'b1111;
      repeat (rdy_delay) begin
        step();
        if (!rsp_valid || (rsp_id !== exp_id[1:0]) || (rsp_t !== et) ||
            (rsp_sq !== es) || (req_ready !== 4'b0)) stable = 1'b0;
      end
      chk({nm, ".held_stable"}, 64'(stable), 64'd1);
      req_valid = hold ? vm : 4'b0;
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk({nm, ".flush_valid"}, 64'(rsp_valid), 64'd0);
    chk({nm, ".flush_sqreset"}, 64'(sq_reset), 64'd1);
    chk({nm, ".flush_busy"}, 64'(busy), 64'd1);
    step();
    chk({nm, ".idle_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int e;
    bit ok;
    tbl[0] = '{4'b0001, 64'd3, 16'h1234, 5, 0, 64'd3};
    tbl[1] = '{4'b0100, 64'd0, 16'hBEEF, 1, 2, 64'd0};
    tbl[2] = '{4'b1011, 64'd2, 16'h0F0F, 2, 3, 64'd2};
    tbl[3] = '{4'b0110, 64'd1, 16'hA5A5, 1, 1, 64'd1};
    tbl[4] = '{4'b0011, 64'd5, 16'h7777, 3, 0, 64'd5};
    tbl[5] = '{4'b1000, 64'd4, 16'h0001, 1, 3, 64'd4};

    reset = 1'b0; req_valid = 4'b0; rsp_ready = 1'b0; sq_locked = 1'b1;
    for (int i = 0; i < 4; i++) begin tb_tf[i] = 64'd0; tb_si[i] = 16'd0; end
    #2 reset = 1'b1;
    #2;
    chk("reset.req_ready", 64'(req_ready), 64'd0);
    chk("reset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("reset.sq_start", 64'(sq_start), 64'd0);
    chk("reset.sq_reset", 64'(sq_reset), 64'd1);
    chk("reset.busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < 4; i++) begin
        tb_tf[i] = tbl[v].tf;
        tb_si[i] = tbl[v].si + 16'(i);
      end
      sq_period = tbl[v].period;
      do_job(tbl[v].vm, tbl[v].exp_id, tbl[v].exp_t, 1'b0, 0, $sformatf("vec%0d", v));
    end

    for (int i = 0; i < 4; i++) tb_tf[i] = 64'd1;
    sq_period = 2;
    for (int j = 0; j < 5; j++) do_job(4'b1111, j % 4, 64'd1, 1'b1, 0, $sformatf("rr%0d", j));
    req_valid = 4'b0;

    tb_tf[2] = 64'd2;
    do_job(4'b0100, 2, 64'd2, 1'b0, 10, "hold_rsp");

    sq_locked = 1'b0;
    req_valid = 4'b0001;
    ok = 1'b1;
    repeat (5) begin
      step();
      if ((busy !== 1'b0) || (req_ready !== 4'b0)) ok = 1'b0;
    end
    chk("unlocked_idle", 64'(ok), 64'd1);
    req_valid = 4'b0;
    sq_locked = 1'b1;
    step();

    tb_tf[0] = 64'd50;
    sq_period = 2;
    req_valid = 4'b0001;
    n = 0;
    while ((req_ready == 4'b0) && (n < 40)) begin step(); n++; end
    chk("lockloss.grant", 64'(req_ready), 64'd1);
    model_ptr = 1;
    req_valid = 4'b0;
    n = 0;
    while (!sq_start && (n < 40)) begin step(); n++; end
    repeat (4) step();
    sq_locked = 1'b0;
    n = 0;
    while (!rsp_valid && (n < 10)) begin step(); n++; end
    chk("lockloss.rsp_valid", 64'(rsp_valid), 64'd1);
    chk("lockloss.rsp_t", rsp_t, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("lockloss.rsp_id", 64'(rsp_id), 64'd0);
    sq_locked = 1'b1;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    chk("lockloss.idle", 64'(busy), 64'd0);

    tb_tf[1] = 64'd20;
    sq_period = 3;
    req_valid = 4'b0010;
    n = 0;
    while ((req_ready == 4'b0) && (n < 40)) begin step(); n++; end
    chk("midreset.grant", 64'(req_ready), 64'd2);
    req_valid = 4'b0;
    n = 0;
    while (!sq_start && (n < 40)) begin step(); n++; end
    repeat (3) step();
    #3 reset = 1'b1;
    #1;
    chk("midreset.busy", 64'(busy), 64'd0);
    chk("midreset.rsp_valid", 64'(rsp_valid), 64'd0);
    chk("midreset.sq_reset", 64'(sq_reset), 64'd1);
    chk("midreset.sq_start", 64'(sq_start), 64'd0);
    step();
    reset = 1'b0;
    model_ptr = 0;
    ok = 1'b1;
    repeat (60) begin
      step();
      if (rsp_valid !== 1'b0) ok = 1'b0;
    end
    chk("midreset.no_rsp", 64'(ok), 64'd1);

    for (int r = 0; r < 40; r++) begin
      logic [3:0] vm;
      vm = 4'($urandom_range(1, 15));
      for (int i = 0; i < 4; i++) begin
        tb_tf[i] = 64'($urandom_range(0, 4));
        tb_si[i] = 16'($urandom);
      end
      sq_period = $urandom_range(1, 3);
      e = model_win(vm);
      do_job(vm, e, tb_tf[e], 1'b0, $urandom_range(0, 2), $sformatf("rnd%0d", r));
    end

`ifdef MSU_SCHED_WDOG_EN
    tb_tf[3] = 64'd100;
    tb_si[3] = 16'h4321;
    sq_period = 2;
    max_pulses = 3;
    e = model_win(4'b1000);
    req_valid = 4'b1000;
    n = 0;
    while ((req_ready == 4'b0) && (n < 40)) begin step(); n++; end
    chk("wdog.grant", 64'(req_ready), 64'd8);
    model_ptr = (e + 1) % 4;
    req_valid = 4'b0;
    n = 0;
    while (!rsp_valid && (n < 1500)) begin step(); n++; end
    chk("wdog.rsp_valid", 64'(rsp_valid), 64'd1);
    chk("wdog.rsp_t", rsp_t, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("wdog.rsp_sq", 64'(rsp_sq), 64'(ref_sq(16'h4321, 64'd3)));
    n = int'(($time - last_pulse_t) / 10);
    chk("wdog.latency_ok", 64'((n >= 1020) && (n <= 1030)), 64'd1);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    step();
    max_pulses = 1000000;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/msu_sched.md
MSU_SCHED -- requirements
Module: msu_sched

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one modular squarer.
REQ-002 Parameter SQ_IN_BITS, default redun_mont_pkg::DAT_BITS: width of the job input value.
REQ-003 Parameter SQ_OUT_BITS, default redun_mont_pkg::TOT_BITS: width of the squarer result, redundant bits included.
REQ-004 Parameter T_LEN, default 64: width of the iteration count.
REQ-005 Parameter WDOG_BITS, default 10: width of the watchdog counter.
REQ-006 clk  in  1  the single clock; all state changes on its rising edge.
REQ-007 reset  in  1  asynchronous, active-high reset.
REQ-008 req_valid  in  NUM_REQ  per-requester job request.
REQ-009 req_ready  out  NUM_REQ  per-requester job accept; one-hot or zero.
REQ-010 req_t_final  in  NUM_REQ*T_LEN  per-requester iteration count; slice i belongs to requester i.
REQ-011 req_sq_in  in  NUM_REQ*SQ_IN_BITS  per-requester input value.
REQ-012 rsp_valid / rsp_ready  out / in  1 / 1  result handshake.
REQ-013 rsp_id  out  $clog2(NUM_REQ)  index of the requester that owns the result.
REQ-014 rsp_t  out  T_LEN  number of iterations completed; all ones on timeout.
REQ-015 rsp_sq  out  SQ_OUT_BITS  result value.
REQ-016 sq_reset / sq_start / sq_in  out / out / out  1 / 1 / SQ_IN_BITS  squarer control signals.
REQ-017 sq_valid / sq_out / sq_locked  in / in / in  1 / SQ_OUT_BITS / 1  squarer per-iteration done pulse, result, and clock-lock status.
REQ-018 busy  out  1  high in every state except IDLE.

Function
REQ-019 States: IDLE, GRANT, START, COMPUTE, RESULT, FLUSH.
REQ-020 IDLE->GRANT when any req_valid bit is high and sq_locked is high; otherwise stay in IDLE.
REQ-021 GRANT: round-robin arbitration starting at (last winner + 1) mod NUM_REQ; after reset the search starts at requester 0.
REQ-022 GRANT: req_ready of the winner is high for exactly this one cycle; its id, t_final and sq_in are latched in the same cycle.
REQ-023 GRANT->RESULT when the latched t_final is 0; rsp_sq is then sq_in zero-extended and rsp_t is 0. Otherwise GRANT->START.
REQ-024 START: sq_start is high for exactly one cycle and sq_in drives the latched value; next state is COMPUTE.
REQ-025 COMPUTE: each sq_valid pulse increments the iteration counter, which starts at 0.
REQ-026 COMPUTE: when the counter reaches t_final, capture sq_out into rsp_sq in the same cycle, set rsp_t = t_final, and go to RESULT.
REQ-027 RESULT: rsp_valid is high and the outputs are held stable until rsp_ready is high; on acceptance go to FLUSH.
REQ-028 FLUSH: sq_reset is high for exactly one cycle, then go to IDLE.
REQ-029 sq_reset is also high throughout IDLE.
REQ-030 A requester that drops req_valid before it is granted is not served; no request is queued beyond its req_valid level.
REQ-031 When req_valid and the grant pointer would select the same requester, the grant goes to that requester.
REQ-032 sq_locked falling during START or COMPUTE ends the job as a timeout: rsp_t all ones, then RESULT.
REQ-033 Counter arithmetic is T_LEN-bit unsigned and never wraps; reaching t_final always ends COMPUTE first.

Reset
REQ-034 On reset assertion, asynchronously: state=IDLE, grant pointer=0, counter=0, watchdog=0.
REQ-035 On reset assertion, asynchronously: req_ready=0, rsp_valid=0, sq_start=0, sq_reset=1, busy=0.
REQ-036 Reset mid-job discards the job; no rsp_valid is produced for it.
REQ-037 Data registers (rsp_sq, rsp_t, rsp_id, sq_in) are not reset.

Configuration
REQ-038 Macro MSU_SCHED_WDOG_EN defined: a WDOG_BITS counter clears on sq_valid and outside COMPUTE, and increments each COMPUTE cycle otherwise.
REQ-039 With MSU_SCHED_WDOG_EN defined, a watchdog count of all ones ends the job as a timeout: rsp_sq = last captured sq_out, rsp_t all ones.
REQ-040 Macro undefined: no watchdog logic; COMPUTE waits indefinitely; only sq_locked loss ends a job early.

Verification
REQ-041 req_valid=4'b0001, t_final=3, sq_valid every 5 cycles -> one sq_start, rsp_valid after the 3rd pulse, rsp_id=0, rsp_t=3, then a 1-cycle sq_reset.
REQ-042 req_valid=4'b1111 held high, t_final=1 for all -> grants in order 0,1,2,3,0.
REQ-043 t_final=0 on requester 2 -> no sq_start, rsp_valid within 2 cycles, rsp_sq=sq_in, rsp_t=0.
REQ-044 rsp_ready held low 10 cycles -> rsp_valid and rsp_* stable, no new grant; rsp_ready=1 -> FLUSH, then IDLE.
REQ-045 With MSU_SCHED_WDOG_EN and sq_valid never pulsing -> rsp_valid after 2^WDOG_BITS-1 COMPUTE cycles, rsp_t all ones; sq_locked=0 mid-COMPUTE -> same timeout response.
REQ-046 reset pulsed during COMPUTE -> outputs reach reset values immediately without a clock edge, and no response is produced.
